// File: rtl/uart_fifo_interface.sv
// 6809 bus UART with independent RX/TX FIFOs, optional parity, sticky line
// errors and a level interrupt. 8N1/8E1/8O1 framing, 16x oversampled receiver.

module uart_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && (level != (AW+1)'(DEPTH));
    assign do_pop  = pop && (level != '0);

    always_ff @(posedge clk) if (do_push) mem[wr_ptr[AW-1:0]] <= din;

    // Flush outranks a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

module uart_fifo_interface #(
    parameter int CLK_HZ     = 88670000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DIVISOR    = (CLK_HZ + BAUD * 8) / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_RW,
    input  logic       i_uart_data_ce,
    input  logic       i_uart_control_ce,
    input  logic       i_UART_TX,
    input  logic [7:0] i_control,
    input  logic [7:0] i_uart_rxdata,
    output logic       o_UART_RX,
    output logic [7:0] o_uart_txdata,
    output logic [7:0] o_uart_status,
    output logic [7:0] o_control,
    output logic       o_IRQ
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(DIVISOR);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} uart_state_t;

    logic          data_ce_q, ctrl_ce_q, data_rw_q, ctrl_rw_q;
    logic          data_rise, ctrl_rise, tx_push, rx_pop, ctrl_wr, err_clr;
    logic [7:0]    ctrl;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [7:0]    tx_head, rx_head;
    logic [LW-1:0] tx_level, rx_level;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    uart_state_t   tx_state, tx_next, rx_state, rx_next;
    logic          tx_pop, tx_line, tx_par_en, tx_par;
    logic [3:0]    tx_tcnt, rx_tcnt;
    logic [2:0]    tx_bit, rx_bit;
    logic [7:0]    tx_shift, rx_shift;
    logic          rx_s1, rx_line, rx_line_q, rx_fall;
    logic          rx_par_en, rx_par_odd, rx_perr, rx_done, rx_push;
    logic [2:0]    sticky;
    logic          irq;

    // Bus strobes: writes act on the CE rising edge, reads on the falling edge.
    assign data_rise = i_uart_data_ce & ~data_ce_q;
    assign ctrl_rise = i_uart_control_ce & ~ctrl_ce_q;
    assign tx_push   = data_rise & ~i_RW;
    assign ctrl_wr   = ctrl_rise & ~i_RW;
    assign rx_pop    = ~i_uart_data_ce & data_ce_q & data_rw_q;
    assign err_clr   = ~i_uart_control_ce & ctrl_ce_q & ctrl_rw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_ce_q <= 1'b0;
            ctrl_ce_q <= 1'b0;
            data_rw_q <= 1'b0;
            ctrl_rw_q <= 1'b0;
            ctrl      <= '0;
            div_cnt   <= '0;
        end else begin
            data_ce_q <= i_uart_data_ce;
            ctrl_ce_q <= i_uart_control_ce;
            if (data_rise) data_rw_q <= i_RW;
            if (ctrl_rise) ctrl_rw_q <= i_RW;
            if (ctrl_wr) ctrl <= {2'b00, i_control[5:0]};
            else         ctrl[5:4] <= 2'b00;
            div_cnt <= tick ? '0 : div_cnt + CW'(1);
        end
    end

    assign tick      = (div_cnt == CW'(DIVISOR - 1));
    assign o_control = ctrl;

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .reset(reset), .flush(ctrl[5]), .push(tx_push), .din(i_uart_rxdata),
        .pop(tx_pop), .head(tx_head), .level(tx_level)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .reset(reset), .flush(ctrl[4]), .push(rx_push), .din(rx_shift),
        .pop(rx_pop), .head(rx_head), .level(rx_level)
    );

    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == LW'(FIFO_DEPTH));
    assign rx_empty = (rx_level == '0);
    assign rx_full  = (rx_level == LW'(FIFO_DEPTH));

    // TX: STOP chains straight into START when more data is queued.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        if (tick) begin
            case (tx_state)
                S_IDLE:  if (!tx_empty && !ctrl[5]) begin tx_next = S_START; tx_pop = 1'b1; end
                S_START: if (tx_tcnt == 4'd15) tx_next = S_DATA;
                S_DATA:  if (tx_tcnt == 4'd15 && tx_bit == 3'd7) tx_next = tx_par_en ? S_PAR : S_STOP;
                S_PAR:   if (tx_tcnt == 4'd15) tx_next = S_STOP;
                S_STOP: begin
                    if (tx_tcnt == 4'd15) begin
                        if (!tx_empty && !ctrl[5]) begin tx_next = S_START; tx_pop = 1'b1; end
                        else tx_next = S_IDLE;
                    end
                end
                default: tx_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= S_IDLE;
            tx_tcnt   <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par_en <= 1'b0;
            tx_par    <= 1'b0;
            tx_line   <= 1'b1;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_tcnt   <= '0;
                tx_bit    <= '0;
                tx_shift  <= tx_head;
                tx_par_en <= ctrl[2];
                tx_par    <= (^tx_head) ^ ctrl[3];
            end else if (tick && tx_state != S_IDLE) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_state == S_DATA && tx_tcnt == 4'd15) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end
            case (tx_state)
                S_START: tx_line <= 1'b0;
                S_DATA:  tx_line <= tx_shift[0];
                S_PAR:   tx_line <= tx_par;
                default: tx_line <= 1'b1;
            endcase
        end
    end

    assign o_UART_RX = tx_line;

    // RX: start validated at mid-bit, later bits sampled every 16 ticks from there.
    assign rx_fall = rx_line_q & ~rx_line;

    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (tick && rx_tcnt == 4'd7) rx_next = rx_line ? S_IDLE : S_DATA;
            S_DATA:  if (tick && rx_tcnt == 4'd15 && rx_bit == 3'd7) rx_next = rx_par_en ? S_PAR : S_STOP;
            S_PAR:   if (tick && rx_tcnt == 4'd15) rx_next = S_STOP;
            S_STOP: begin
                if (tick && rx_tcnt == 4'd15) begin
                    rx_next = S_IDLE;
                    rx_done = 1'b1;
                end
            end
            default: rx_next = S_IDLE;
        endcase
    end

    assign rx_push = rx_done & rx_line & ~rx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_line    <= 1'b1;
            rx_line_q  <= 1'b1;
            rx_state   <= S_IDLE;
            rx_tcnt    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_perr    <= 1'b0;
        end else begin
            rx_s1     <= i_UART_TX;
            rx_line   <= rx_s1;
            rx_line_q <= rx_line;
            rx_state  <= rx_next;
            if (rx_state == S_IDLE) begin
                rx_tcnt <= '0;
                rx_bit  <= '0;
                rx_perr <= 1'b0;
                if (rx_fall) begin
                    rx_par_en  <= ctrl[2];
                    rx_par_odd <= ctrl[3];
                end
            end else if (tick) begin
                rx_tcnt <= (rx_state == S_START && rx_tcnt == 4'd7) ? 4'd0 : rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd15 && rx_state == S_DATA) begin
                    rx_shift <= {rx_line, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
                if (rx_tcnt == 4'd15 && rx_state == S_PAR)
                    rx_perr <= rx_line ^ (^rx_shift) ^ rx_par_odd;
            end
        end
    end

    // Sticky errors {parity, framing, overrun}; a new event outranks the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky        <= '0;
            o_uart_txdata <= '0;
            o_IRQ         <= 1'b1;
        end else begin
            sticky <= (err_clr ? 3'b000 : sticky) |
                      {rx_done & rx_line & rx_perr, rx_done & ~rx_line, rx_done & rx_line & rx_full};
            o_uart_txdata <= rx_empty ? 8'h00 : rx_head;
            o_IRQ         <= ~irq;
        end
    end

    assign irq = (ctrl[0] & (~rx_empty | (|sticky))) | (ctrl[1] & tx_empty);

    assign o_uart_status = {irq, rx_level >= LW'(FIFO_DEPTH / 2), sticky,
                            tx_empty && (tx_state == S_IDLE), ~tx_full, ~rx_empty};
endmodule

// File: tb/tb_uart_fifo_interface.sv
// Directed bench for uart_fifo_interface: bus access, TX framing, RX with
// parity/framing/overrun errors, IRQ and TX flush.

module tb_uart_fifo_interface;
    localparam int DIV   = 4;
    localparam int BIT   = 16 * DIV;
    localparam int FRAME = 11 * BIT;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_RW, i_uart_data_ce, i_uart_control_ce, i_UART_TX;
    logic [7:0] i_control, i_uart_rxdata;
    logic       o_UART_RX, o_IRQ;
    logic [7:0] o_uart_txdata, o_uart_status, o_control;

    int n_chk  = 0;
    int n_fail = 0;

    uart_fifo_interface #(.FIFO_DEPTH(16), .DIVISOR(DIV)) dut (
        .clk(clk), .reset(reset), .i_RW(i_RW), .i_uart_data_ce(i_uart_data_ce),
        .i_uart_control_ce(i_uart_control_ce), .i_UART_TX(i_UART_TX), .i_control(i_control),
        .i_uart_rxdata(i_uart_rxdata), .o_UART_RX(o_UART_RX), .o_uart_txdata(o_uart_txdata),
        .o_uart_status(o_uart_status), .o_control(o_control), .o_IRQ(o_IRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input bit ctl, input logic [7:0] d);
        @(negedge clk);
        i_RW = 1'b0;
        if (ctl) begin i_control = d; i_uart_control_ce = 1'b1; end
        else begin i_uart_rxdata = d; i_uart_data_ce = 1'b1; end
        @(negedge clk);
        i_uart_control_ce = 1'b0;
        i_uart_data_ce    = 1'b0;
        i_RW              = 1'b1;
    endtask

    task automatic bus_rd(input bit ctl, output logic [7:0] d);
        @(negedge clk);
        i_RW = 1'b1;
        if (ctl) i_uart_control_ce = 1'b1;
        else     i_uart_data_ce    = 1'b1;
        @(negedge clk);
        d = ctl ? o_uart_status : o_uart_txdata;
        i_uart_control_ce = 1'b0;
        i_uart_data_ce    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop_bit);
        i_UART_TX = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_UART_TX = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (par_en) begin
            i_UART_TX = par_bit;
            repeat (BIT) @(negedge clk);
        end
        i_UART_TX = stop_bit;
        repeat (BIT) @(negedge clk);
        i_UART_TX = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd, rxb;
        int n;
        reset = 1'b1; i_RW = 1'b1; i_uart_data_ce = 1'b0; i_uart_control_ce = 1'b0;
        i_UART_TX = 1'b1; i_control = '0; i_uart_rxdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_line", o_UART_RX, 1);
        chk("rst_irq", o_IRQ, 1);
        chk("rst_status", o_uart_status, 8'h06);
        chk("rst_control", o_control, 8'h00);
        chk("rst_txdata", o_uart_txdata, 8'h00);

        // TX 0x55, 8N1
        bus_wr(1'b0, 8'h55);
        n = 0;
        while (o_UART_RX && n < 50) begin n++; @(negedge clk); end
        chk("tx_start_seen", o_UART_RX, 0);
        n = 0;
        while (!o_UART_RX && n < 200) begin n++; @(negedge clk); end
        chk("tx_start_len", n, BIT);
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxb[i] = o_UART_RX;
            if (i == 3) chk("tx_busy_status2", o_uart_status[2], 0);
            if (i < 7) repeat (BIT) @(negedge clk);
        end
        chk("tx_byte", rxb, 8'h55);
        repeat (BIT) @(negedge clk);
        chk("tx_stop", o_UART_RX, 1);
        n = 0;
        while (!o_uart_status[2] && n < 2 * BIT) begin n++; @(negedge clk); end
        chk("tx_idle_after", o_uart_status[2], 1);

        // Control mask, flush self-clear, TX-empty IRQ
        bus_wr(1'b1, 8'hFF);
        repeat (2) @(negedge clk);
        chk("ctrl_mask", o_control, 8'h0F);
        chk("ctrl_txirq", o_IRQ, 0);

        // RX 0xA3 with odd parity and IRQ enabled
        bus_wr(1'b1, 8'h0D);
        repeat (2) @(negedge clk);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        chk("rx_status", o_uart_status, 8'h87);
        chk("rx_head", o_uart_txdata, 8'hA3);
        chk("rx_irq", o_IRQ, 0);
        bus_rd(1'b0, rd);
        chk("rx_read", rd, 8'hA3);
        chk("rx_status_after", o_uart_status, 8'h06);
        chk("rx_irq_after", o_IRQ, 1);

        // Overrun: 17 bytes into a 16-deep FIFO
        bus_wr(1'b1, 8'h00);
        repeat (2) @(negedge clk);
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        chk("ovr_status", o_uart_status, 8'h4F);
        bus_rd(1'b1, rd);
        chk("ovr_cleared", o_uart_status, 8'h47);
        for (int i = 0; i < 16; i++) begin
            bus_rd(1'b0, rd);
            chk($sformatf("ovr_byte%0d", i), rd, i);
        end
        chk("ovr_drained", o_uart_status, 8'h06);
        chk("ovr_txdata0", o_uart_txdata, 8'h00);

        // Framing error: byte discarded
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("frm_status", o_uart_status, 8'h16);
        bus_rd(1'b1, rd);
        chk("frm_cleared", o_uart_status, 8'h06);

        // Parity error (even mode, wrong bit): byte kept
        bus_wr(1'b1, 8'h04);
        repeat (2) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        chk("par_status", o_uart_status, 8'h27);
        bus_rd(1'b0, rd);
        chk("par_byte", rd, 8'h3C);
        bus_rd(1'b1, rd);
        chk("par_cleared", o_uart_status, 8'h06);

        // TX burst of 17 fills FIFO behind the shifter, then flush mid-frame
        bus_wr(1'b1, 8'h00);
        repeat (2) @(negedge clk);
        for (int i = 0; i <= 16; i++) bus_wr(1'b0, 8'h80 + 8'(i));
        @(negedge clk);
        chk("burst_full", o_uart_status[1], 0);
        bus_wr(1'b1, 8'h20);
        repeat (2) @(negedge clk);
        chk("flush_selfclr", o_control, 8'h00);
        chk("flush_notfull", o_uart_status[1], 1);
        chk("flush_busy", o_uart_status[2], 0);
        n = 0;
        while (!o_uart_status[2] && n < 2 * FRAME) begin n++; @(negedge clk); end
        chk("flush_idle", o_uart_status[2], 1);
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (!o_UART_RX) n++;
            @(negedge clk);
        end
        chk("flush_quiet", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
